// File: rtl/barrier_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : barrier_arbiter_if
// Brief   : Core request / barrier counter signal bundle for barrier_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface barrier_arbiter_if #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 2
);
    localparam int IDW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic [NUM_CORES-1:0]              core_req_i;
    logic [NUM_CORES*IDW-1:0]          core_bar_id_i;
    logic [NUM_BARRIERS-1:0]           flush_i;
    logic [NUM_BARRIERS*NUM_CORES-1:0] barrier_event_i;
    logic [NUM_CORES-1:0]              core_gnt_o;
    logic [NUM_BARRIERS-1:0]           barrier_get_o;
    logic [NUM_BARRIERS-1:0]           clear_req_o;
    logic [NUM_CORES-1:0]              core_wait_o;
    logic [NUM_CORES-1:0]              core_wakeup_o;
    logic                              spurious_o;

    modport master (
        output core_req_i, core_bar_id_i, flush_i, barrier_event_i,
        input  core_gnt_o, barrier_get_o, clear_req_o, core_wait_o,
               core_wakeup_o, spurious_o
    );

    modport slave (
        input  core_req_i, core_bar_id_i, flush_i, barrier_event_i,
        output core_gnt_o, barrier_get_o, clear_req_o, core_wait_o,
               core_wakeup_o, spurious_o
    );
endinterface
`default_nettype wire

// File: rtl/barrier_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : barrier_arbiter
// Brief   : Round-robin barrier arrival arbiter with per-core wait/wakeup FSM.
// Revision: 1.0 - initial release
// ============================================================================
module barrier_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 2
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    barrier_arbiter_if.slave  bus
);
    localparam int IDW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} core_state_t;

    core_state_t             r_state    [NUM_CORES];
    core_state_t             w_state_nxt[NUM_CORES];
    logic [IDW-1:0]          r_id       [NUM_CORES];
    logic [IDW-1:0]          w_id_nxt   [NUM_CORES];
    logic [CW-1:0]           r_ptr, w_ptr_nxt;

    logic [NUM_CORES-1:0]    w_wake, w_elig, w_gnt;
    logic                    w_found, w_win_oor, w_spur;
    logic [CW-1:0]           w_win;
    logic [IDW-1:0]          w_win_id;
    logic [NUM_BARRIERS-1:0] w_get;

    logic [NUM_CORES-1:0]    r_gnt, r_wake;
    logic [NUM_BARRIERS-1:0] r_get, r_clear;
    logic                    r_spur;

    // Release and spurious-event detection; only in-range ids are ever latched.
    always_comb begin
        w_wake = '0;
        w_elig = '0;
        w_spur = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_wake[c] = (r_state[c] == WAIT) &&
                        (bus.barrier_event_i[int'(r_id[c])*NUM_CORES + c] ||
                         bus.flush_i[r_id[c]]);
            w_elig[c] = (r_state[c] == IDLE) && bus.core_req_i[c] && !w_wake[c];
        end
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (bus.barrier_event_i[b*NUM_CORES + c] &&
                    !((r_state[c] == WAIT) && (r_id[c] == IDW'(b)))) begin
                    w_spur = 1'b1;
                end
            end
        end
    end

    // Round-robin search starting at the pointer (last winner + 1).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NUM_CORES;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = CW'(idx);
            end
        end
        w_win_id  = bus.core_bar_id_i[int'(w_win)*IDW +: IDW];
        w_win_oor = w_found && (int'(w_win_id) >= NUM_BARRIERS);
        w_gnt     = '0;
        w_get     = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_gnt[c] = w_found && (w_win == CW'(c));
        end
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_get[b] = w_found && !w_win_oor && (w_win_id == IDW'(b));
        end
        w_ptr_nxt = r_ptr;
        if (w_found) begin
            w_ptr_nxt = (w_win == CW'(NUM_CORES-1)) ? '0 : w_win + 1'b1;
        end
    end

    // Per-core next state: wakeup returns to IDLE, an in-range grant parks in WAIT.
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            w_state_nxt[c] = r_state[c];
            w_id_nxt[c]    = r_id[c];
            if (w_wake[c]) begin
                w_state_nxt[c] = IDLE;
            end
            if (w_gnt[c] && !w_win_oor) begin
                w_state_nxt[c] = WAIT;
                w_id_nxt[c]    = w_win_id;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                r_state[c] <= IDLE;
                r_id[c]    <= '0;
            end
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_wake  <= '0;
            r_get   <= '0;
            r_clear <= '0;
            r_spur  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_id[c]    <= w_id_nxt[c];
            end
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt;
            r_wake  <= w_wake;
            r_get   <= w_get;
            r_clear <= bus.flush_i;
            r_spur  <= w_spur | w_win_oor;
        end
    end

    assign bus.core_gnt_o    = r_gnt;
    assign bus.core_wakeup_o = r_wake;
    assign bus.barrier_get_o = r_get;
    assign bus.clear_req_o   = r_clear;
    assign bus.spurious_o    = r_spur;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_wait
        assign bus.core_wait_o[c] = (r_state[c] == WAIT);
    end
endmodule
`default_nettype wire
